serialtx_arb: RTL and testbench
===============================

SERIALTX_ARB -- requirements
Module: serialtx_arb

Interface
REQ-001 Parameter NUM_REQ, 4, number of byte requesters (2..8); SHALL be honoured throughout.
REQ-002 Parameter FRAME, 8, byte width; SHALL match the transmitter's FRAME.
REQ-003 Parameter WB_ADDR, 32'h0, transmitter address; SHALL be driven on wb_addr.
REQ-004 clk  input  1  sole clock; all state SHALL update on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  NUM_REQ  per-requester byte available.
REQ-007 req_data  input  NUM_REQ*FRAME  byte of requester i at bits [i*FRAME +: FRAME].
REQ-008 req_last  input  NUM_REQ  byte closes requester's message.
REQ-009 req_ready  output  NUM_REQ  one-hot pulse; byte taken when valid && ready.
REQ-010 wb_cyc, wb_stb, wb_we  output  1 each  Wishbone master controls.
REQ-011 wb_addr  output  32; wb_data_w  output  FRAME  write address/data.
REQ-012 wb_ack, wb_stall  input  1 each  Wishbone slave responses.
REQ-013 grant_id  output  $clog2(NUM_REQ)  requester owning current/last transfer.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 FSM SHALL have states IDLE, STROBE, WAIT_ACK.
REQ-016 IDLE: if any eligible req_valid, SHALL pick winner by round-robin starting at pointer rr_ptr, assert req_ready[winner] that cycle, latch data/last/id, go STROBE next cycle; else stay IDLE with req_ready all zero.
REQ-017 STROBE: wb_cyc=wb_stb=wb_we=1, wb_data_w=latched byte; if !wb_stall go WAIT_ACK, else remain with cyc/stb/we/data/addr stable.
REQ-018 WAIT_ACK: wb_cyc=1, wb_stb=0; on wb_ack go IDLE and set rr_ptr = (winner+1) mod NUM_REQ.
REQ-019 IDLE: wb_cyc=wb_stb=wb_we=0.
REQ-020 Latency: req_ready to first wb_stb exactly 1 cycle; ack to next req_ready at least 1 cycle (ack in cycle N, IDLE pick in N+1).
REQ-021 At most one Wishbone transaction outstanding; wb_ack outside WAIT_ACK SHALL be ignored.
REQ-022 rr_ptr wrap: NUM_REQ-1 +1 -> 0; pointer SHALL update only on ack.
REQ-023 A requester dropping req_valid while not granted SHALL NOT be penalised; no byte is lost or duplicated.
REQ-024 req_ready SHALL never be asserted to a requester whose req_valid is low.

Reset
REQ-025 On rst: state=IDLE, rr_ptr=0, grant_id=0, req_ready=0, wb_cyc=wb_stb=wb_we=0, wb_data_w=0, busy=0, lock cleared; effective next edge.
REQ-026 rst in STROBE/WAIT_ACK SHALL abandon the transaction without re-issuing it; a late wb_ack after reset SHALL be ignored.

Configuration
REQ-027 Macro SERIALTX_ARB_MSG_LOCK_EN defined: after a byte with req_last=0 is acked, only that requester is eligible until its req_last=1 byte is acked; rr_ptr advances only then.
REQ-028 Macro undefined: req_last ignored, arbitration per byte, no lock state.

Structure
REQ-029 Package serialtx_arb_pkg SHALL hold the state enum and default NUM_REQ/FRAME constants.
REQ-030 Sub-module rr_pick SHALL be the combinational round-robin selector (valid vector, pointer -> one-hot grant, index, any).

Verification
REQ-031 Single: req0 valid, data 8'hA5, stall 0 -> ready0 one cycle, stb next cycle with data A5, ack -> IDLE, rr_ptr=1.
REQ-032 Contention: req0..req3 valid continuously, data 8'h10..8'h13 -> transmitted order 10,11,12,13,10; each ready pulse one-hot.
REQ-033 Stall: wb_stall held 5 cycles in STROBE -> stb, we, data, addr stable all 5 cycles; WAIT_ACK entered on first !stall.
REQ-034 Reset: rst pulse in WAIT_ACK, then ack -> outputs at reset values, ack ignored, no ready pulse until valid re-sampled.
REQ-035 Lock (macro on): req1 sends 3 bytes last=0,0,1 while req2 valid -> all 3 req1 bytes before any req2 byte; macro off -> order req1,req2,req1,req2,req1.
REQ-036 Wrap: NUM_REQ=4, only req3 and req0 valid -> alternating 3,0,3,0.

Source files
------------

// File: rtl/serialtx_arb_pkg.sv
// Shared types and default sizing for the serialtx_arb byte arbiter.
package serialtx_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        STROBE   = 2'd1,
        WAIT_ACK = 2'd2
    } state_t;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_FRAME   = 8;

endpackage

// File: rtl/serialtx_arb_rr_pick.sv
// Combinational round-robin selector: first valid requester at or after ptr.
module rr_pick #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    always_comb begin
        int pos;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        pos   = 0;
        // Walk from the farthest slot back toward ptr so the closest valid one wins.
        for (int k = N - 1; k >= 0; k--) begin
            pos = (int'(ptr) + k) % N;
            if (valid[pos]) begin
                grant      = '0;
                grant[pos] = 1'b1;
                idx        = pos[IW-1:0];
                any        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/serialtx_arb.sv
// Round-robin arbiter feeding bytes from NUM_REQ requesters to a Wishbone transmitter.
// Optional SERIALTX_ARB_MSG_LOCK_EN keeps the grant on one requester until its req_last byte.
module serialtx_arb
    import serialtx_arb_pkg::*;
#(
    parameter  int          NUM_REQ = DEF_NUM_REQ,
    parameter  int          FRAME   = DEF_FRAME,
    parameter  logic [31:0] WB_ADDR = 32'h0,
    localparam int          IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*FRAME-1:0] req_data,
    input  logic [NUM_REQ-1:0]       req_last,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     wb_cyc,
    output logic                     wb_stb,
    output logic                     wb_we,
    output logic [31:0]              wb_addr,
    output logic [FRAME-1:0]         wb_data_w,
    input  logic                     wb_ack,
    input  logic                     wb_stall,
    output logic [IDX_W-1:0]         grant_id,
    output logic                     busy
);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, grant_q, next_ptr;
    logic [FRAME-1:0]   data_q, sel_data;
    logic [NUM_REQ-1:0] elig, pick_grant;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;

`ifdef SERIALTX_ARB_MSG_LOCK_EN
    logic               last_q, lock_q, sel_last;
    logic [NUM_REQ-1:0] lock_mask;

    always_comb begin
        lock_mask           = '0;
        lock_mask[grant_q]  = 1'b1;
        elig = lock_q ? (req_valid & lock_mask) : req_valid;
    end
`else
    logic unused_last;
    assign unused_last = ^req_last;
    assign elig        = req_valid;
`endif

    rr_pick #(.N(NUM_REQ)) u_pick (
        .valid (elig),
        .ptr   (rr_ptr_q),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    always_comb begin
        sel_data = '0;
`ifdef SERIALTX_ARB_MSG_LOCK_EN
        sel_last = 1'b0;
`endif
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == IDX_W'(i)) begin
                sel_data = req_data[i*FRAME +: FRAME];
`ifdef SERIALTX_ARB_MSG_LOCK_EN
                sel_last = req_last[i];
`endif
            end
        end
    end

    assign next_ptr = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            data_q   <= '0;
`ifdef SERIALTX_ARB_MSG_LOCK_EN
            last_q   <= 1'b0;
            lock_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && pick_any) begin
                grant_q <= pick_idx;
                data_q  <= sel_data;
`ifdef SERIALTX_ARB_MSG_LOCK_EN
                last_q  <= sel_last;
`endif
            end
            // Pointer only moves once the transmitter has acknowledged the byte.
            if (state_q == WAIT_ACK && wb_ack) begin
`ifdef SERIALTX_ARB_MSG_LOCK_EN
                if (!last_q) begin
                    lock_q <= 1'b1;
                end else begin
                    lock_q   <= 1'b0;
                    rr_ptr_q <= next_ptr;
                end
`else
                rr_ptr_q <= next_ptr;
`endif
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        wb_cyc    = 1'b0;
        wb_stb    = 1'b0;
        wb_we     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_any && !rst) begin
                    req_ready = pick_grant;
                    state_d   = STROBE;
                end
            end
            STROBE: begin
                wb_cyc = 1'b1;
                wb_stb = 1'b1;
                wb_we  = 1'b1;
                if (!wb_stall) state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                wb_cyc = 1'b1;
                if (wb_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign wb_addr   = WB_ADDR;
    assign wb_data_w = data_q;
    assign grant_id  = grant_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_serialtx_arb.sv
// Randomized self-checking bench for serialtx_arb against a queue-based arbitration model.
module tb_serialtx_arb;

    localparam int          N    = 4;
    localparam int          FR   = 8;
    localparam logic [31:0] ADDR = 32'hA000_0010;
`ifdef SERIALTX_ARB_MSG_LOCK_EN
    localparam bit LOCK_MODE = 1'b1;
`else
    localparam bit LOCK_MODE = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*FR-1:0] req_data;
    logic [N-1:0]    req_last;
    logic [N-1:0]    req_ready;
    logic            wb_cyc, wb_stb, wb_we;
    logic [31:0]     wb_addr;
    logic [FR-1:0]   wb_data_w;
    logic            wb_ack, wb_stall;
    logic [1:0]      grant_id;
    logic            busy;

    always #5 clk = ~clk;

    serialtx_arb #(.NUM_REQ(N), .FRAME(FR), .WB_ADDR(ADDR)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .wb_cyc    (wb_cyc),
        .wb_stb    (wb_stb),
        .wb_we     (wb_we),
        .wb_addr   (wb_addr),
        .wb_data_w (wb_data_w),
        .wb_ack    (wb_ack),
        .wb_stall  (wb_stall),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    int checks = 0;
    int errors = 0;

    // Model state: phase 0 idle, 1 strobing, 2 waiting for ack.
    int         phase, m_ptr, m_lock_id, exp_id, stall_cnt, stall_max, ack_wait, g_ack_max;
    bit         m_lock, exp_last;
    logic [7:0] exp_data;
    logic [8:0] rq [N][$];
    int         tx_id[$];
    logic [7:0] tx_data[$];

    task automatic push(input int r, input logic [7:0] d, input bit l);
        rq[r].push_back({l, d});
    endtask

    function automatic bit queues_empty();
        for (int i = 0; i < N; i++)
            if (rq[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_clear();
        phase = 0; m_ptr = 0; m_lock = 1'b0; m_lock_id = 0;
        stall_cnt = 0; stall_max = 0; ack_wait = 0;
        for (int i = 0; i < N; i++) rq[i].delete();
        tx_id.delete();
        tx_data.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1; req_valid = '0; wb_ack = 1'b0; wb_stall = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear();
    endtask

    task automatic drive_inputs(input int stall_pct, input int drop_pct, input int fixed_stall);
        for (int i = 0; i < N; i++) begin
            if (rq[i].size() > 0 && $urandom_range(99) >= drop_pct) begin
                req_valid[i]        = 1'b1;
                req_data[i*FR +: FR] = rq[i][0][7:0];
                req_last[i]         = rq[i][0][8];
            end else begin
                req_valid[i]        = 1'b0;
                req_data[i*FR +: FR] = 8'($urandom);
                req_last[i]         = 1'($urandom_range(1));
            end
        end
        if (fixed_stall >= 0) wb_stall = (phase == 1 && stall_cnt < fixed_stall);
        else                  wb_stall = ($urandom_range(99) < stall_pct);
        if (phase == 2) wb_ack = (ack_wait == 0);
        else            wb_ack = ($urandom_range(99) < 5);
    endtask

    task automatic check_cycle();
        int         win;
        logic [N-1:0] exp_rdy;
        win = -1;
        exp_rdy = '0;
        case (phase)
            0: begin
                for (int k = 0; k < N; k++) begin
                    int i;
                    i = (m_ptr + k) % N;
                    if (win < 0 && req_valid[i] && (!m_lock || i == m_lock_id)) win = i;
                end
                if (win >= 0) exp_rdy[win] = 1'b1;
                checks++;
                if (req_ready !== exp_rdy) begin
                    errors++;
                    $display("FAIL idle_ready: got %b want %b (valid %b)", req_ready, exp_rdy, req_valid);
                end
                checks++;
                if ({wb_cyc, wb_stb, wb_we, busy} !== 4'b0000) begin
                    errors++;
                    $display("FAIL idle_ctl: got cyc/stb/we/busy %b want 0000", {wb_cyc, wb_stb, wb_we, busy});
                end
                if (win >= 0) begin
                    {exp_last, exp_data} = rq[win].pop_front();
                    exp_id    = win;
                    phase     = 1;
                    stall_cnt = 0;
                end
            end
            1: begin
                checks++;
                if ({wb_cyc, wb_stb, wb_we, busy} !== 4'b1111) begin
                    errors++;
                    $display("FAIL strobe_ctl: got cyc/stb/we/busy %b want 1111", {wb_cyc, wb_stb, wb_we, busy});
                end
                checks++;
                if (wb_data_w !== exp_data || wb_addr !== ADDR) begin
                    errors++;
                    $display("FAIL strobe_data: got %h@%h want %h@%h", wb_data_w, wb_addr, exp_data, ADDR);
                end
                checks++;
                if (grant_id !== 2'(exp_id) || req_ready !== '0) begin
                    errors++;
                    $display("FAIL strobe_grant: got id %0d ready %b want id %0d ready 0", grant_id, req_ready, exp_id);
                end
                if (wb_stall) begin
                    stall_cnt++;
                    if (stall_cnt > stall_max) stall_max = stall_cnt;
                end else begin
                    phase    = 2;
                    ack_wait = $urandom_range(g_ack_max, 0);
                end
            end
            default: begin
                checks++;
                if ({wb_cyc, wb_stb, busy} !== 3'b101 || req_ready !== '0) begin
                    errors++;
                    $display("FAIL wait_ctl: got cyc/stb/busy %b ready %b want 101 ready 0", {wb_cyc, wb_stb, busy}, req_ready);
                end
                checks++;
                if (grant_id !== 2'(exp_id)) begin
                    errors++;
                    $display("FAIL wait_grant: got %0d want %0d", grant_id, exp_id);
                end
                if (wb_ack) begin
                    tx_id.push_back(exp_id);
                    tx_data.push_back(exp_data);
                    if (LOCK_MODE && !exp_last) begin
                        m_lock = 1'b1; m_lock_id = exp_id;
                    end else begin
                        m_lock = 1'b0; m_ptr = (exp_id + 1) % N;
                    end
                    phase = 0;
                end else begin
                    ack_wait--;
                end
            end
        endcase
    endtask

    task automatic run_engine(input int budget, input int stall_pct, input int drop_pct,
                              input int fixed_stall, input int stop_phase);
        int n;
        n = 0;
        @(posedge clk); #1;
        drive_inputs(stall_pct, drop_pct, fixed_stall);
        forever begin
            @(negedge clk);
            check_cycle();
            if (stop_phase >= 0) begin
                if (phase == stop_phase) return;
            end else if (queues_empty() && phase == 0) begin
                return;
            end
            n++;
            if (n >= budget) begin
                checks++; errors++;
                $display("FAIL engine_timeout: got %0d cycles without draining, limit %0d", n, budget);
                return;
            end
            @(posedge clk); #1;
            drive_inputs(stall_pct, drop_pct, fixed_stall);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = '1; req_data = 32'h4433_2211; req_last = '1;
        wb_ack = 1'b1; wb_stall = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (req_ready !== '0 || {wb_cyc, wb_stb, wb_we, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctl: got ready %b ctl %b want 0", req_ready, {wb_cyc, wb_stb, wb_we, busy});
        end
        checks++;
        if (grant_id !== 2'd0 || wb_data_w !== 8'h00) begin
            errors++;
            $display("FAIL reset_regs: got id %0d data %h want 0/00", grant_id, wb_data_w);
        end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        g_ack_max = 2;
        push(0, 8'hA5, 1'b1);
        run_engine(50, 0, 0, -1, -1);
        checks++;
        if (tx_id.size() != 1 || tx_data[0] !== 8'hA5 || tx_id[0] != 0) begin
            errors++;
            $display("FAIL single_tx: got %0d bytes first %h want 1 byte A5 from req0", tx_id.size(), tx_data[0]);
        end
        push(0, 8'h5A, 1'b1);
        push(1, 8'h66, 1'b1);
        run_engine(50, 0, 0, -1, -1);
        checks++;
        if (tx_id.size() != 3 || tx_id[1] != 1 || tx_id[2] != 0) begin
            errors++;
            $display("FAIL single_ptr: got order %p want req1 then req0", tx_id);
        end
    endtask

    task automatic test_contention();
        int exp_ids[5]        = '{0, 1, 2, 3, 0};
        logic [7:0] exp_d[5]  = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
        do_reset();
        g_ack_max = 1;
        push(0, 8'h10, 1'b1); push(0, 8'h10, 1'b1);
        push(1, 8'h11, 1'b1); push(2, 8'h12, 1'b1); push(3, 8'h13, 1'b1);
        run_engine(100, 0, 0, -1, -1);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (i >= tx_id.size() || tx_id[i] != exp_ids[i] || tx_data[i] !== exp_d[i]) begin
                errors++;
                $display("FAIL contention_order[%0d]: got %p / %p want id %0d data %h", i, tx_id, tx_data, exp_ids[i], exp_d[i]);
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        g_ack_max = 0;
        push(1, 8'h3C, 1'b1);
        run_engine(50, 0, 0, 5, -1);
        checks++;
        if (stall_max != 5 || tx_data.size() != 1 || tx_data[0] !== 8'h3C) begin
            errors++;
            $display("FAIL stall_hold: got %0d stalled cycles, %0d bytes want 5 cycles one byte 3C", stall_max, tx_data.size());
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        g_ack_max = 0;
        push(2, 8'hC3, 1'b1);
        run_engine(50, 0, 0, -1, 2);
        @(posedge clk); #1;
        rst = 1'b1; wb_ack = 1'b0; wb_stall = 1'b0; req_valid = '0;
        @(negedge clk);
        checks++;
        if ({wb_cyc, wb_stb, busy} !== 3'b101 || grant_id !== 2'd2) begin
            errors++;
            $display("FAIL midreset_pre: got ctl %b id %0d want 101 id 2", {wb_cyc, wb_stb, busy}, grant_id);
        end
        @(posedge clk); #1;
        rst = 1'b0; wb_ack = 1'b1;
        @(negedge clk);
        checks++;
        if ({wb_cyc, wb_stb, wb_we, busy} !== 4'b0000 || req_ready !== '0 ||
            grant_id !== 2'd0 || wb_data_w !== 8'h00) begin
            errors++;
            $display("FAIL midreset_post: got ctl %b ready %b id %0d data %h want all 0",
                     {wb_cyc, wb_stb, wb_we, busy}, req_ready, grant_id, wb_data_w);
        end
        @(posedge clk); #1;
        wb_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || req_ready !== '0) begin
            errors++;
            $display("FAIL midreset_ack: got busy %b ready %b want 0/0", busy, req_ready);
        end
        model_clear();
        push(1, 8'h77, 1'b1);
        push(3, 8'h88, 1'b1);
        run_engine(50, 0, 0, -1, -1);
        checks++;
        if (tx_id.size() != 2 || tx_id[0] != 1 || tx_id[1] != 3) begin
            errors++;
            $display("FAIL midreset_resume: got order %p want req1 then req3 only", tx_id);
        end
    endtask

    task automatic test_lock();
        int exp_ids[5];
        logic [7:0] exp_d[5];
`ifdef SERIALTX_ARB_MSG_LOCK_EN
        exp_ids = '{1, 1, 1, 2, 2};
        exp_d   = '{8'h21, 8'h22, 8'h23, 8'h31, 8'h32};
`else
        exp_ids = '{1, 2, 1, 2, 1};
        exp_d   = '{8'h21, 8'h31, 8'h22, 8'h32, 8'h23};
`endif
        do_reset();
        g_ack_max = 2;
        push(1, 8'h21, 1'b0); push(1, 8'h22, 1'b0); push(1, 8'h23, 1'b1);
        push(2, 8'h31, 1'b1); push(2, 8'h32, 1'b1);
        run_engine(100, 0, 0, -1, -1);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (i >= tx_id.size() || tx_id[i] != exp_ids[i] || tx_data[i] !== exp_d[i]) begin
                errors++;
                $display("FAIL lock_order[%0d]: got %p want id %0d data %h", i, tx_id, exp_ids[i], exp_d[i]);
            end
        end
    endtask

    task automatic test_wrap();
        int exp_ids[4] = '{3, 0, 3, 0};
        do_reset();
        g_ack_max = 1;
        push(1, 8'h01, 1'b1);
        run_engine(50, 0, 0, -1, -1);
        tx_id.delete();
        tx_data.delete();
        push(3, 8'hA3, 1'b1); push(3, 8'hB3, 1'b1);
        push(0, 8'hA0, 1'b1); push(0, 8'hB0, 1'b1);
        run_engine(100, 0, 0, -1, -1);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= tx_id.size() || tx_id[i] != exp_ids[i]) begin
                errors++;
                $display("FAIL wrap_order[%0d]: got %p want %0d", i, tx_id, exp_ids[i]);
            end
        end
    endtask

    task automatic test_random(input int stall_pct, input int drop_pct, input int ack_max);
        int total, n;
        do_reset();
        g_ack_max = ack_max;
        total = 0;
        for (int r = 0; r < N; r++) begin
            n = $urandom_range(12, 0);
            for (int j = 0; j < n; j++)
                push(r, 8'($urandom), (j == n - 1) ? 1'b1 : 1'($urandom_range(1)));
            total += n;
        end
        run_engine(6000, stall_pct, drop_pct, -1, -1);
        checks++;
        if (tx_id.size() != total) begin
            errors++;
            $display("FAIL random_count: got %0d bytes want %0d", tx_id.size(), total);
        end
    endtask

    task automatic test_back_to_back();
        test_random(0, 0, 0);
    endtask

    initial begin
        req_data = '0; req_last = '0; req_valid = '0;
        wb_ack = 1'b0; wb_stall = 1'b0; rst = 1'b1;
        g_ack_max = 0;
        model_clear();
        test_reset();
        test_single();
        test_contention();
        test_stall();
        test_reset_midflight();
        test_lock();
        test_wrap();
        test_back_to_back();
        for (int i = 0; i < 4; i++) test_random(30, 25, 3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish within 2 ms, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
